// File: rtl/decodor_cezar_stream.sv
// Streaming Caesar decoder: valid/ready byte input, runtime key, one decode stage feeding a small output FIFO.
// Optional accepted-letter counter (letter_cnt port) is enabled by defining CEZAR_DEC_CNT_EN.
module decodor_cezar_stream #(
    parameter int SHIFT = 3,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  key_in,
    input  logic        key_load,
    output logic        key_err,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
`ifdef CEZAR_DEC_CNT_EN
    ,
    output logic [15:0] letter_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [4:0]    KEY_RST = 5'(SHIFT);
    localparam logic [AW+1:0] DEPTH_W = (AW + 2)'(DEPTH);

    logic [4:0]  key_reg;
    logic        key_err_reg;
    logic        stage_valid_reg;
    logic [7:0]  stage_data_reg;
    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;

    logic [AW:0]   fifo_count;
    logic [AW+1:0] occupancy;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic          accept;
    logic          key_ok;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7a);
    endfunction

    function automatic logic is_upper(input logic [7:0] c);
        return (c >= 8'h41) && (c <= 8'h5a);
    endfunction

    // Subtract the key modulo 26 without a divider: lift the offset by 26 when it would go negative.
    function automatic logic [7:0] decode(input logic [7:0] c, input logic [4:0] k);
        logic [7:0] base;
        logic [5:0] off;
        logic [5:0] kk;
        base = is_lower(c) ? 8'h61 : 8'h41;
        off  = 6'(c - base);
        kk   = {1'b0, k};
        if (off < kk) begin
            off = off + 6'd26;
        end
        off = off - kk;
        if (is_lower(c) || is_upper(c)) begin
            return base + {2'b00, off};
        end
        return c;
    endfunction

    assign fifo_count = wr_ptr_reg - rd_ptr_reg;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    assign occupancy  = {1'b0, fifo_count} + (AW + 2)'(stage_valid_reg);
    assign pop        = !fifo_empty && out_ready;
    assign push       = stage_valid_reg;

    // The stage always drains into the FIFO next edge, so counting it here guarantees room for that push.
    assign in_ready   = (occupancy < DEPTH_W) || pop;
    assign accept     = in_valid && in_ready;
    assign key_ok     = (key_in <= 5'd25);

    assign out_valid  = !fifo_empty;
    assign out_data   = fifo_empty ? 8'h00 : mem[rd_ptr_reg[AW-1:0]];
    assign key_err    = key_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_reg     <= KEY_RST;
            key_err_reg <= 1'b0;
        end else begin
            key_err_reg <= key_load && !key_ok;
            if (key_load && key_ok) begin
                key_reg <= key_in;
            end
        end
    end

    // A byte accepted on a key-load edge still sees the old key_reg value here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid_reg <= 1'b0;
            stage_data_reg  <= 8'h00;
        end else begin
            stage_valid_reg <= accept;
            if (accept) begin
                stage_data_reg <= decode(in_data, key_reg);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg[AW-1:0]] <= stage_data_reg;
        end
    end

`ifdef CEZAR_DEC_CNT_EN
    logic [15:0] letter_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            letter_cnt_reg <= 16'h0000;
        end else if (accept && (is_lower(in_data) || is_upper(in_data))
                     && (letter_cnt_reg != 16'hFFFF)) begin
            letter_cnt_reg <= letter_cnt_reg + 16'd1;
        end
    end

    assign letter_cnt = letter_cnt_reg;
`endif

endmodule

// File: tb/tb_decodor_cezar_stream.sv
// Directed bench for decodor_cezar_stream: vector table plus latency, backpressure, key, reset and round-trip sequences.
module tb_decodor_cezar_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  key_in;
    logic        key_load;
    logic        key_err;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
`ifdef CEZAR_DEC_CNT_EN
    logic [15:0] letter_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    decodor_cezar_stream #(.SHIFT(3), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .key_in    (key_in),
        .key_load  (key_load),
        .key_err   (key_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef CEZAR_DEC_CNT_EN
        ,
        .letter_cnt(letter_cnt)
`endif
    );

    typedef struct packed {
        logic [7:0] din;
        logic [4:0] key;
        logic [7:0] dexp;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp, input bit quiet);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else if (!quiet) begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [4:0] k);
        key_in   = k;
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
    endtask

    // One byte through an idle pipeline with out_ready held high.
    task automatic send_one(input string name, input logic [7:0] din, input logic [7:0] dexp);
        out_ready = 1'b1;
        in_data   = din;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        tick();
        chk(name, {7'b0, out_valid, out_data}, {8'h01, dexp}, 1'b0);
        tick();
    endtask

    function automatic logic [7:0] encode3(input logic [7:0] c);
        logic [7:0] base;
        base = (c >= 8'h61) ? 8'h61 : 8'h41;
        return base + 8'((int'(c - base) + 3) % 26);
    endfunction

    function automatic logic [7:0] rand_letter();
        int r;
        r = int'($urandom_range(0, 51));
        if (r < 26) return 8'(8'h61 + r);
        return 8'(8'h41 + r - 26);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        logic [7:0] bp [5];
        logic [7:0] bp_exp [4];
        logic [7:0] orig_q [$];
        logic [7:0] cur_orig;
        logic [7:0] exp_b;
        logic [4:0] cur_key;
        int acc;
        int idx;
        int got;
        int sent;
        int rcvd;

        vecs[0]  = '{8'h61, 5'd3,  8'h78};  // a -> x
        vecs[1]  = '{8'h43, 5'd3,  8'h5a};  // C -> Z
        vecs[2]  = '{8'h21, 5'd3,  8'h21};
        vecs[3]  = '{8'hff, 5'd3,  8'hff};
        vecs[4]  = '{8'h64, 5'd3,  8'h61};  // d -> a
        vecs[5]  = '{8'h5a, 5'd3,  8'h57};  // Z -> W
        vecs[6]  = '{8'h78, 5'd3,  8'h75};  // x -> u
        vecs[7]  = '{8'h40, 5'd3,  8'h40};  // just below 'A'
        vecs[8]  = '{8'h5b, 5'd3,  8'h5b};  // just above 'Z'
        vecs[9]  = '{8'h60, 5'd3,  8'h60};  // just below 'a'
        vecs[10] = '{8'h7b, 5'd3,  8'h7b};  // just above 'z'
        vecs[11] = '{8'h71, 5'd0,  8'h71};  // key 0 passes through
        vecs[12] = '{8'h61, 5'd25, 8'h62};  // a -> b
        vecs[13] = '{8'h5a, 5'd25, 8'h41};  // Z -> A
        vecs[14] = '{8'h61, 5'd1,  8'h7a};  // a -> z
        vecs[15] = '{8'h6e, 5'd13, 8'h61};  // n -> a

        bp     = '{8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
        bp_exp = '{8'h62, 8'h63, 8'h64, 8'h65};

        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        key_in    = 5'd0;
        key_load  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        chk("reset out_valid", 16'(out_valid), 16'h0000, 1'b0);
        chk("reset out_data", 16'(out_data), 16'h0000, 1'b0);
        chk("reset key_err", 16'(key_err), 16'h0000, 1'b0);
        chk("reset in_ready", 16'(in_ready), 16'h0001, 1'b0);

        // "dpn" back to back: one-edge latency, one byte per cycle out.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h64;
        tick();
        in_data   = 8'h70;
        tick();
        chk("stream a", {7'b0, out_valid, out_data}, 16'h0161, 1'b0);
        in_data   = 8'h6e;
        tick();
        chk("stream m", {7'b0, out_valid, out_data}, 16'h016d, 1'b0);
        in_valid  = 1'b0;
        tick();
        chk("stream k", {7'b0, out_valid, out_data}, 16'h016b, 1'b0);
        tick();
        chk("stream empty", 16'(out_valid), 16'h0000, 1'b0);

        cur_key = 5'd3;
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].key != cur_key) begin
                load_key(vecs[i].key);
                cur_key = vecs[i].key;
            end
            send_one($sformatf("vec%0d", i), vecs[i].din, vecs[i].dexp);
        end
        load_key(5'd3);

        // Backpressure: four bytes fill stage + FIFO, then in_ready must drop.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        acc = 0;
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            in_data = bp[idx];
            @(negedge clk);
            if (in_ready) begin
                acc++;
                idx++;
            end
            tick();
        end
        chk("bp accepted", 16'(acc), 16'd4, 1'b0);
        chk("bp in_ready low", 16'(in_ready), 16'h0000, 1'b0);
        chk("bp head stable", {7'b0, out_valid, out_data}, 16'h0162, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp in_ready on pop", 16'(in_ready), 16'h0001, 1'b0);
        got = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid && out_ready && got < 4) begin
                chk($sformatf("bp drain%0d", got), 16'(out_data), 16'(bp_exp[got]), 1'b0);
                got++;
            end
            tick();
        end
        chk("bp drained", {got[7:0], 7'b0, out_valid}, {8'd4, 8'h00}, 1'b0);

        // Key load on the same edge as an accept: that byte keeps the old key.
        key_in    = 5'd1;
        key_load  = 1'b1;
        in_data   = 8'h65;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        key_load  = 1'b0;
        tick();
        chk("old key e->b", {7'b0, out_valid, out_data}, 16'h0162, 1'b0);
        in_valid  = 1'b0;
        tick();
        chk("new key e->d", {7'b0, out_valid, out_data}, 16'h0164, 1'b0);
        tick();
        key_in   = 5'd27;
        key_load = 1'b1;
        chk("key_err idle", 16'(key_err), 16'h0000, 1'b0);
        tick();
        key_load = 1'b0;
        chk("key_err pulse", 16'(key_err), 16'h0001, 1'b0);
        tick();
        chk("key_err clears", 16'(key_err), 16'h0000, 1'b0);
        send_one("key kept b->a", 8'h62, 8'h61);

        // Reset with three bytes buffered.
        out_ready = 1'b0;
        in_data   = 8'h61;
        in_valid  = 1'b1;
        repeat (3) tick();
        in_valid  = 1'b0;
        tick();
        chk("prereset out_valid", 16'(out_valid), 16'h0001, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async out_valid", 16'(out_valid), 16'h0000, 1'b0);
        chk("async out_data", 16'(out_data), 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("postreset in_ready", {7'b0, in_ready, 7'b0, out_valid}, 16'h0100, 1'b0);
`ifdef CEZAR_DEC_CNT_EN
        chk("postreset letter_cnt", letter_cnt, 16'h0000, 1'b0);
`endif
        send_one("postreset key d->a", 8'h64, 8'h61);

        // Round trip through a shift-3 encoder model with random backpressure.
        sent = 0;
        rcvd = 0;
        cur_orig = rand_letter();
        for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (sent < 1000) begin
                in_valid = 1'b1;
                in_data  = encode3(cur_orig);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (out_valid && out_ready) begin
                if (orig_q.size() == 0) begin
                    chk("roundtrip spurious", 16'(out_data), 16'hffff, 1'b0);
                end else begin
                    exp_b = orig_q.pop_front();
                    chk($sformatf("roundtrip%0d", rcvd), 16'(out_data), 16'(exp_b), 1'b1);
                end
                rcvd++;
            end
            if (in_valid && in_ready) begin
                orig_q.push_back(cur_orig);
                sent++;
                cur_orig = rand_letter();
            end
            tick();
        end
        in_valid = 1'b0;
        chk("roundtrip count", 16'(rcvd), 16'd1000, 1'b0);
`ifdef CEZAR_DEC_CNT_EN
        chk("letter_cnt", letter_cnt, 16'd1001, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
